// File: rtl/seven_seg_pkg.sv
// Shared glyph constants for active-low abcdefg 7-segment displays (a = bit 6).
// Hex glyphs are reused by the ASCII table so both modes render digits identically.
package seven_seg_pkg;

   localparam logic       MODE_HEX   = 1'b0;
   localparam logic       MODE_ASCII = 1'b1;

   localparam logic [6:0] SEG_BLANK  = 7'b1111111;
   localparam logic [6:0] SEG_DASH   = 7'b1111110;
   localparam logic [6:0] SEG_EQUAL  = 7'b1110110;
   localparam logic [6:0] SEG_UNDER  = 7'b1110111;

   localparam logic [6:0] G_0 = 7'b0000001;
   localparam logic [6:0] G_1 = 7'b1001111;
   localparam logic [6:0] G_2 = 7'b0010010;
   localparam logic [6:0] G_3 = 7'b0000110;
   localparam logic [6:0] G_4 = 7'b1001100;
   localparam logic [6:0] G_5 = 7'b0100100;
   localparam logic [6:0] G_6 = 7'b0100000;
   localparam logic [6:0] G_7 = 7'b0001111;
   localparam logic [6:0] G_8 = 7'b0000000;
   localparam logic [6:0] G_9 = 7'b0000100;
   localparam logic [6:0] G_A = 7'b0001000;
   localparam logic [6:0] G_B = 7'b1100000;
   localparam logic [6:0] G_C = 7'b0110001;
   localparam logic [6:0] G_D = 7'b1000010;
   localparam logic [6:0] G_E = 7'b0110000;
   localparam logic [6:0] G_F = 7'b0111000;

   // Letters that have no hex counterpart
   localparam logic [6:0] G_G = 7'b0100001;
   localparam logic [6:0] G_H = 7'b1001000;
   localparam logic [6:0] G_J = 7'b1000011;
   localparam logic [6:0] G_L = 7'b1110001;
   localparam logic [6:0] G_N = 7'b1101010;
   localparam logic [6:0] G_P = 7'b0011000;
   localparam logic [6:0] G_R = 7'b1111010;
   localparam logic [6:0] G_T = 7'b1110000;
   localparam logic [6:0] G_U = 7'b1000001;
   localparam logic [6:0] G_Y = 7'b1000100;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = G_0;
         4'h1: g = G_1;
         4'h2: g = G_2;
         4'h3: g = G_3;
         4'h4: g = G_4;
         4'h5: g = G_5;
         4'h6: g = G_6;
         4'h7: g = G_7;
         4'h8: g = G_8;
         4'h9: g = G_9;
         4'hA: g = G_A;
         4'hB: g = G_B;
         4'hC: g = G_C;
         4'hD: g = G_D;
         4'hE: g = G_E;
         default: g = G_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational code-to-glyph decoder (hex or ASCII) with blanking.
// dp_en is low whenever the digit is blanked so the caller can gate its decimal point.
module seven_seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [7:0] code,
   input  logic       mode,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp_en
);

   logic [7:0] up_code;

   // Case-fold lower-case letters so one table serves both
   always_comb begin
      up_code = code;
      if (code >= 8'h61 && code <= 8'h7A) up_code = code - 8'h20;
   end

   function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
      logic [6:0] g;
      g = SEG_BLANK;
      if (c >= 8'h30 && c <= 8'h39) begin
         g = hex_glyph(c[3:0]);
      end else begin
         case (c)
            8'h41: g = G_A;
            8'h42: g = G_B;
            8'h43: g = G_C;
            8'h44: g = G_D;
            8'h45: g = G_E;
            8'h46: g = G_F;
            8'h47: g = G_G;
            8'h48: g = G_H;
            8'h49: g = G_1;
            8'h4A: g = G_J;
            8'h4C: g = G_L;
            8'h4E: g = G_N;
            8'h4F: g = G_0;
            8'h50: g = G_P;
            8'h52: g = G_R;
            8'h53: g = G_5;
            8'h54: g = G_T;
            8'h55: g = G_U;
            8'h59: g = G_Y;
            8'h2D: g = SEG_DASH;
            8'h3D: g = SEG_EQUAL;
            8'h5F: g = SEG_UNDER;
            default: g = SEG_BLANK;
         endcase
      end
      return g;
   endfunction

   always_comb begin
      seg   = SEG_BLANK;
      dp_en = ~blank;
      if (!blank) begin
         if (mode == MODE_HEX) seg = hex_glyph(code[3:0]);
         else                  seg = ascii_glyph(up_code);
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed, double-buffered 7-segment scan driver with PWM brightness.
// Shadow data is promoted to the active buffer only at frame boundaries.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SCAN_DIV_BITS = 16,
   parameter int BRIGHT_BITS   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*NUM_DIGITS-1:0] dataIn,
   input  logic [NUM_DIGITS-1:0]   modeIn,
   input  logic [NUM_DIGITS-1:0]   dpIn,
   input  logic [NUM_DIGITS-1:0]   blankIn,
   input  logic                    load,
   input  logic [BRIGHT_BITS-1:0]  brightness,
   output logic                    pending,
   output logic                    frameStart,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   typedef struct packed {
      logic [8*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   mode;
      logic [NUM_DIGITS-1:0]   point;
      logic [NUM_DIGITS-1:0]   blank;
   } disp_buf_t;

   localparam disp_buf_t RST_BUF = '{data: '0, mode: '0, point: '0, blank: '1};

   logic [SCAN_DIV_BITS-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   disp_buf_t                act_q, act_d;
   disp_buf_t                shd_q, shd_d;
   logic                     pending_q, pending_d;
   logic                     frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0]    anode_q, anode_d;
   logic [6:0]               seg_q, seg_d;
   logic                     dp_q, dp_d;

   disp_buf_t                in_buf;
   logic                     scan_tick, frame_bnd, pwm_on;
   logic [BRIGHT_BITS-1:0]   slot_top;
   logic [7:0]               cur_code;
   logic                     cur_mode, cur_point, cur_blank;
   logic [6:0]               dec_seg;
   logic                     dec_dp_en;

   // Scan timing
   always_comb begin
      scan_tick = &cnt_q;
      frame_bnd = scan_tick && (idx_q == LAST_IDX);
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      if (scan_tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      frame_start_d = frame_bnd;
   end

   // Double buffer: a load coinciding with the boundary bypasses the shadow
   always_comb begin
      in_buf    = '{data: dataIn, mode: modeIn, point: dpIn, blank: blankIn};
      shd_d     = shd_q;
      act_d     = act_q;
      pending_d = pending_q;
      if (load) begin
         shd_d     = in_buf;
         pending_d = 1'b1;
      end
      if (frame_bnd) begin
         if (load) begin
            act_d     = in_buf;
            pending_d = 1'b0;
         end else if (pending_q) begin
            act_d     = shd_q;
            pending_d = 1'b0;
         end
      end
   end

   always_comb begin
      cur_code  = act_q.data[idx_q*8 +: 8];
      cur_mode  = act_q.mode[idx_q];
      cur_point = act_q.point[idx_q];
      cur_blank = act_q.blank[idx_q];
   end

   seven_seg_glyph_decode u_decode (
      .code  (cur_code),
      .mode  (cur_mode),
      .blank (cur_blank),
      .seg   (dec_seg),
      .dp_en (dec_dp_en)
   );

   // PWM gates only the anode; segments stay driven for the whole slot
   always_comb begin
      slot_top = cnt_q[SCAN_DIV_BITS-1 -: BRIGHT_BITS];
      pwm_on   = (slot_top <= brightness);
      anode_d  = '1;
      if (pwm_on) anode_d[idx_q] = 1'b0;
      seg_d    = dec_seg;
      dp_d     = ~(cur_point & dec_dp_en);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         act_q         <= RST_BUF;
         shd_q         <= RST_BUF;
         pending_q     <= 1'b0;
         frame_start_q <= 1'b0;
         anode_q       <= '1;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         act_q         <= act_d;
         shd_q         <= shd_d;
         pending_q     <= pending_d;
         frame_start_q <= frame_start_d;
         anode_q       <= anode_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign pending    = pending_q;
   assign frameStart = frame_start_q;
   assign anode      = anode_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a cycle-level display model
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_seven_seg_scan_driver;

   localparam int N    = 4;
   localparam int SLOT = 16;
   localparam int FRAME = N * SLOT;

   logic          clk;
   logic          reset;
   logic [31:0]   dataIn;
   logic [3:0]    modeIn, dpIn, blankIn;
   logic          load;
   logic [3:0]    brightness;
   logic          pending, frameStart;
   logic [3:0]    anode;
   logic [6:0]    seg;
   logic          dp;

   int checks   = 0;
   int failures = 0;

   seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV_BITS(4), .BRIGHT_BITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .dataIn     (dataIn),
      .modeIn     (modeIn),
      .dpIn       (dpIn),
      .blankIn    (blankIn),
      .load       (load),
      .brightness (brightness),
      .pending    (pending),
      .frameStart (frameStart),
      .anode      (anode),
      .seg        (seg),
      .dp         (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   function automatic logic [6:0] model_glyph(logic [7:0] c, logic mode, logic blank);
      logic [7:0] ch;
      if (blank) return 7'b1111111;
      if (!mode) return hex_tab[c[3:0]];
      ch = c;
      if (ch >= "a" && ch <= "z") ch = ch - 8'h20;
      if (ch >= "0" && ch <= "9") return hex_tab[ch[3:0]];
      case (ch)
         "A": return hex_tab[10];
         "B": return hex_tab[11];
         "C": return hex_tab[12];
         "D": return hex_tab[13];
         "E": return hex_tab[14];
         "F": return hex_tab[15];
         "G": return 7'b0100001;
         "H": return 7'b1001000;
         "I": return 7'b1001111;
         "J": return 7'b1000011;
         "L": return 7'b1110001;
         "N": return 7'b1101010;
         "O": return hex_tab[0];
         "P": return 7'b0011000;
         "R": return 7'b1111010;
         "S": return hex_tab[5];
         "T": return 7'b1110000;
         "U": return 7'b1000001;
         "Y": return 7'b1000100;
         "-": return 7'b1111110;
         "=": return 7'b1110110;
         "_": return 7'b1110111;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: t counts clocks since reset release, so slot position and digit
   // follow from plain arithmetic. Outputs reflect the state before the last edge.
   int          m_t;
   logic [31:0] m_act_data, m_shd_data;
   logic [3:0]  m_act_mode, m_act_dp, m_act_blank, m_shd_mode, m_shd_dp, m_shd_blank;
   logic        m_pend, m_fs, m_dp;
   logic [3:0]  m_anode;
   logic [6:0]  m_seg;

   task automatic model_reset();
      m_t = 0;
      m_act_data = '0; m_act_mode = '0; m_act_dp = '0; m_act_blank = '1;
      m_shd_data = '0; m_shd_mode = '0; m_shd_dp = '0; m_shd_blank = '1;
      m_pend = 1'b0; m_fs = 1'b0; m_anode = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
   endtask

   task automatic model_step();
      int  pos, dig;
      logic bnd;
      if (reset) begin
         model_reset();
         return;
      end
      pos = m_t % SLOT;
      dig = (m_t / SLOT) % N;
      bnd = ((m_t % FRAME) == FRAME - 1);
      m_anode = 4'hF;
      if (pos <= int'(brightness)) m_anode[dig] = 1'b0;
      m_seg = model_glyph(m_act_data[dig*8 +: 8], m_act_mode[dig], m_act_blank[dig]);
      m_dp  = !(m_act_dp[dig] && !m_act_blank[dig]);
      m_fs  = bnd;
      if (bnd && load) begin
         m_act_data = dataIn; m_act_mode = modeIn; m_act_dp = dpIn; m_act_blank = blankIn;
      end else if (bnd && m_pend) begin
         m_act_data = m_shd_data; m_act_mode = m_shd_mode;
         m_act_dp = m_shd_dp; m_act_blank = m_shd_blank;
      end
      if (load) begin
         m_shd_data = dataIn; m_shd_mode = modeIn; m_shd_dp = dpIn; m_shd_blank = blankIn;
      end
      m_pend = bnd ? 1'b0 : (m_pend || load);
      m_t++;
   endtask

   // Compare process: every cycle once reset has been seen on an edge
   initial begin
      model_reset();
      @(posedge clk);
      while (!reset) @(posedge clk);
      forever begin
         @(negedge clk);
         check("m_anode", {28'd0, anode}, {28'd0, m_anode});
         check("m_seg", {25'd0, seg}, {25'd0, m_seg});
         check("m_dp", {31'd0, dp}, {31'd0, m_dp});
         check("m_pending", {31'd0, pending}, {31'd0, m_pend});
         check("m_frameStart", {31'd0, frameStart}, {31'd0, m_fs});
         check("one_hot_anode", {31'd0, ($countones(~anode) <= 1)}, 32'd1);
         model_step();
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fs();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frameStart && k < 200);
      check("wait_frameStart", {31'd0, frameStart}, 32'd1);
   endtask

   task automatic pulse_load(logic [31:0] d, logic [3:0] m, logic [3:0] p, logic [3:0] b);
      dataIn = d; modeIn = m; dpIn = p; blankIn = b; load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   int period, lows;

   initial begin
      reset = 1'b1; load = 1'b0; dataIn = '0; modeIn = '0; dpIn = '0; blankIn = '0;
      brightness = 4'hF;
      step(3);
      reset = 1'b0;

      // Reset state and idle frame cadence
      @(negedge clk);
      check("idle_pending", {31'd0, pending}, 32'd0);
      check("idle_seg", {25'd0, seg}, 32'h7F);
      wait_fs();
      period = 0;
      do begin
         @(negedge clk);
         period++;
      end while (!frameStart && period < 200);
      check("fs_period", period, FRAME);
      check("idle_dp", {31'd0, dp}, 32'd1);

      // Hex display
      step(3);
      pulse_load(32'h04030201, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      check("hex_pending", {31'd0, pending}, 32'd1);
      wait_fs();
      check("hex_pending_clr", {31'd0, pending}, 32'd0);
      repeat (5) @(negedge clk);
      check("hex_d0_anode", {28'd0, anode}, 32'hE);
      check("hex_d0_seg", {25'd0, seg}, {25'd0, 7'b1001111});
      repeat (48) @(negedge clk);
      check("hex_d3_anode", {28'd0, anode}, 32'h7);
      check("hex_d3_seg", {25'd0, seg}, {25'd0, 7'b1001100});

      // ASCII "HELP" with dp on digit 1
      step(1);
      pulse_load(32'h504C4548, 4'b1111, 4'b0010, 4'b0000);
      wait_fs();
      repeat (5) @(negedge clk);
      check("asc_H", {25'd0, seg}, {25'd0, 7'b1001000});
      check("asc_H_dp", {31'd0, dp}, 32'd1);
      repeat (16) @(negedge clk);
      check("asc_E", {25'd0, seg}, {25'd0, 7'b0110000});
      check("asc_E_dp", {31'd0, dp}, 32'd0);
      repeat (32) @(negedge clk);
      check("asc_P", {25'd0, seg}, {25'd0, 7'b0011000});
      step(1);
      pulse_load(32'h504B4548, 4'b1111, 4'b0010, 4'b0000);
      wait_fs();
      repeat (37) @(negedge clk);
      check("asc_K_blank", {25'd0, seg}, 32'h7F);

      // Tear-free swap: two loads during digit 1, latest wins at next frame
      wait_fs();
      step(20);
      pulse_load(32'h0A0B0C0D, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      check("swap_pending", {31'd0, pending}, 32'd1);
      check("swap_d1_old", {25'd0, seg}, {25'd0, 7'b0110000});
      step(4);
      pulse_load(32'h00000F0E, 4'b0000, 4'b0000, 4'b0000);
      repeat (12) @(negedge clk);
      check("swap_d2_old", {25'd0, seg}, 32'h7F);
      wait_fs();
      repeat (5) @(negedge clk);
      check("swap_d0_new", {25'd0, seg}, {25'd0, 7'b0110000});
      repeat (16) @(negedge clk);
      check("swap_d1_new", {25'd0, seg}, {25'd0, 7'b0111000});

      // Load in the boundary cycle goes straight to the active buffer
      wait_fs();
      step(63);
      pulse_load(32'h00000008, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      check("bnd_fs", {31'd0, frameStart}, 32'd1);
      check("bnd_pending", {31'd0, pending}, 32'd0);
      @(negedge clk);
      check("bnd_d0_seg", {25'd0, seg}, {25'd0, 7'b0000000});

      // Brightness 3: four lit clocks in any 16-clock window
      brightness = 4'd3;
      step(2);
      lows = 0;
      repeat (16) begin
         @(negedge clk);
         if (anode != 4'hF) lows++;
      end
      check("pwm_low_count", lows, 4);

      // Reset while a load is pending
      step(1);
      pulse_load(32'h01010101, 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_pending", {31'd0, pending}, 32'd0);
      check("rst_anode", {28'd0, anode}, 32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      wait_fs();
      repeat (5) @(negedge clk);
      check("rst_discard_seg", {25'd0, seg}, 32'h7F);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
